// File: rtl/spi_word_sequencer.sv
// SPI mode-0 master that streams queued 64-bit words under one CS window and captures replies.
// Define SPI_BOOT_WAIT_EN to add the boot_done port and hold transfers until target boot completes.
module spi_word_sequencer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CLKDIV     = 2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [63:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
`ifdef SPI_BOOT_WAIT_EN
  input  logic        boot_done,
`endif
  output logic        SCK,
  output logic        CS,
  output logic        COPI,
  input  logic        CIPO,
  output logic [63:0] rx_word,
  output logic        rx_valid,
  output logic        busy
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned HW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [HW-1:0] H_LAST   = HW'(CLKDIV - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DESEL, HOLD} state_t;

  logic [63:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop, fifo_empty, gate;
  logic [63:0]   head;

  state_t        state;
  logic [HW-1:0] hcnt;
  logic          h_last;
  logic [5:0]    bit_cnt, next_bit;
  logic          word_end;
  logic [63:0]   tx_word, rx_shift, rx_next;

  // Serial bit k maps to byte k/8, MSB first within the byte.
  function automatic logic [5:0] bit_idx(input logic [5:0] k);
    bit_idx = {k[5:3], ~k[2:0]};
  endfunction

  assign fifo_empty = (count == '0);
  assign word_ready = !reset && (count != FULL_CNT);
  assign push       = word_valid && word_ready;
  assign head       = mem[rd_ptr];
  assign busy       = !CS || !fifo_empty;

`ifdef SPI_BOOT_WAIT_EN
  logic boot_flag;

  always_ff @(posedge CLK) begin
    if (reset)
      boot_flag <= 1'b0;
    else if (boot_done)
      boot_flag <= 1'b1;
  end

  assign gate = boot_flag;
`else
  assign gate = 1'b1;
`endif

  assign h_last   = (hcnt == H_LAST);
  assign next_bit = bit_cnt + 6'd1;
  assign word_end = (state == HIGH) && h_last && (bit_cnt == 6'd63);
  assign pop      = !fifo_empty && (((state == IDLE) && gate) || word_end);

  always_comb begin
    rx_next = rx_shift;
    rx_next[bit_idx(bit_cnt)] = CIPO;
  end

  always_ff @(posedge CLK) begin
    if (push)
      mem[wr_ptr] <= word_in;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= IDLE;
      hcnt     <= '0;
      bit_cnt  <= '0;
      tx_word  <= '0;
      rx_shift <= '0;
      CS       <= 1'b1;
      SCK      <= 1'b0;
      COPI     <= 1'b0;
      rx_word  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      hcnt     <= h_last ? '0 : hcnt + 1'b1;
      case (state)
        IDLE: begin
          hcnt <= '0;
          CS   <= 1'b1;
          SCK  <= 1'b0;
          if (pop) begin
            tx_word <= head;
            COPI    <= head[7];
            CS      <= 1'b0;
            bit_cnt <= '0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (h_last) begin
            SCK   <= 1'b1;
            state <= HIGH;
          end
        end
        HIGH: begin
          if (h_last) begin
            SCK      <= 1'b0;
            rx_shift <= rx_next;
            bit_cnt  <= next_bit;
            if (bit_cnt == 6'd63) begin
              rx_word  <= rx_next;
              rx_valid <= 1'b1;
              // Chain straight into the next queued word: its bit0 replaces
              // the setup phase, so CS stays low with no gap.
              if (!fifo_empty) begin
                tx_word <= head;
                COPI    <= head[7];
                state   <= LOW;
              end else begin
                COPI  <= 1'b0;
                state <= DESEL;
              end
            end else begin
              COPI  <= tx_word[bit_idx(next_bit)];
              state <= LOW;
            end
          end
        end
        LOW: begin
          if (h_last) begin
            SCK   <= 1'b1;
            state <= HIGH;
          end
        end
        DESEL: begin
          if (h_last) begin
            CS    <= 1'b1;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (h_last)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_word_sequencer.sv
// Directed bench for spi_word_sequencer: CLKDIV=2 instance for most vectors, CLKDIV=1 instance
// for the fast-clock vector; boot gating vectors run when SPI_BOOT_WAIT_EN is defined.
`timescale 1ns/1ps
module tb_spi_word_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // CLKDIV=2 instance
  logic        rst, wvalid, wready, sck, cs, copi, cipo, rxv, busy, loop, cipo_drv;
  logic [63:0] win, rxw;
`ifdef SPI_BOOT_WAIT_EN
  logic        boot_done;
`endif
  assign cipo = loop ? copi : cipo_drv;

  spi_word_sequencer #(.FIFO_DEPTH(8), .CLKDIV(2)) dut (
    .CLK(clk), .reset(rst), .word_in(win), .word_valid(wvalid), .word_ready(wready),
`ifdef SPI_BOOT_WAIT_EN
    .boot_done(boot_done),
`endif
    .SCK(sck), .CS(cs), .COPI(copi), .CIPO(cipo),
    .rx_word(rxw), .rx_valid(rxv), .busy(busy)
  );

  // CLKDIV=1 instance, always in loopback
  logic        rst1, wvalid1, wready1, sck1, cs1, copi1, rxv1, busy1;
  logic [63:0] win1, rxw1;

  spi_word_sequencer #(.FIFO_DEPTH(4), .CLKDIV(1)) dut1 (
    .CLK(clk), .reset(rst1), .word_in(win1), .word_valid(wvalid1), .word_ready(wready1),
`ifdef SPI_BOOT_WAIT_EN
    .boot_done(1'b1),
`endif
    .SCK(sck1), .CS(cs1), .COPI(copi1), .CIPO(copi1),
    .rx_word(rxw1), .rx_valid(rxv1), .busy(busy1)
  );

  // Monitor for the CLKDIV=2 instance, sampled on the falling CLK edge
  logic        sck_q = 1'b0, cs_q = 1'b1;
  int unsigned rises = 0, cs_falls = 0, rxv_cnt = 0, cs_fall_cyc = 0, cs_rise_cyc = 0;
  logic        tx_q[$];
  int unsigned rise_q[$];
  int unsigned rxv_q[$];
  logic [63:0] rxw_q[$];

  always @(negedge clk) begin
    if (sck && !sck_q) begin
      rises++;
      tx_q.push_back(copi);
      rise_q.push_back(cyc);
    end
    if (!cs && cs_q) begin
      cs_falls++;
      cs_fall_cyc = cyc;
    end
    if (cs && !cs_q) cs_rise_cyc = cyc;
    if (rxv) begin
      rxv_cnt++;
      rxv_q.push_back(cyc);
      rxw_q.push_back(rxw);
    end
    sck_q = sck;
    cs_q  = cs;
  end

  // Monitor for the CLKDIV=1 instance
  logic        sck1_q = 1'b0, cs1_q = 1'b1;
  int unsigned rises1 = 0, rxv1_cnt = 0, cs1_fall_cyc = 0, rxv1_cyc = 0;
  int unsigned rise1_q[$];

  always @(negedge clk) begin
    if (sck1 && !sck1_q) begin
      rises1++;
      rise1_q.push_back(cyc);
    end
    if (!cs1 && cs1_q) cs1_fall_cyc = cyc;
    if (rxv1) begin
      rxv1_cnt++;
      rxv1_cyc = cyc;
    end
    sck1_q = sck1;
    cs1_q  = cs1;
  end

  int unsigned n_vec = 0, n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_a(input logic [63:0] w, output int unsigned hs_cyc);
    int unsigned t;
    t = 0;
    win = w;
    wvalid = 1'b1;
    while (!wready && t < 3000) begin
      tick();
      t++;
    end
    if (!wready) check("push_timeout", 64'd0, 64'd1);
    tick();
    hs_cyc = cyc;
    wvalid = 1'b0;
  endtask

  task automatic wait_idle_a();
    int unsigned t;
    t = 0;
    while (busy && t < 20000) begin
      tick();
      t++;
    end
    if (busy) check("idle_timeout", 64'd0, 64'd1);
    tick(4);
  endtask

  task automatic wait_rises_a(input int unsigned target);
    int unsigned t;
    t = 0;
    while (rises < target && t < 5000) begin
      tick();
      t++;
    end
    if (rises < target) check("rise_timeout", 64'd0, 64'd1);
  endtask

  // Reassemble a transmitted word from the captured COPI stream
  function automatic logic [63:0] decode(input int unsigned base);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < 64; k++) w[8*(k/8) + 7 - (k%8)] = tx_q[base + k];
    return w;
  endfunction

  function automatic int unsigned bad_gaps(input int unsigned base, input int unsigned n,
                                           input int unsigned gap);
    int unsigned b;
    b = 0;
    for (int i = 1; i < int'(n); i++)
      if (rise_q[base + i] - rise_q[base + i - 1] != gap) b++;
    return b;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned r0, f0, v0, hs, dummy, t, bad;
    logic [63:0] seq;
    logic [63:0] w3 [3];

    rst = 1'b1; wvalid = 1'b0; win = '0; loop = 1'b0; cipo_drv = 1'b0;
    rst1 = 1'b1; wvalid1 = 1'b0; win1 = '0;
`ifdef SPI_BOOT_WAIT_EN
    boot_done = 1'b0;
`endif
    tick(2);
    check("rst_cs", 64'(cs), 64'd1);
    check("rst_sck", 64'(sck), 64'd0);
    check("rst_copi", 64'(copi), 64'd0);
    check("rst_rx_word", rxw, 64'd0);
    check("rst_rx_valid", 64'(rxv), 64'd0);
    check("rst_word_ready", 64'(wready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    rst1 = 1'b0;
    tick();
    check("ready_after_rst", 64'(wready), 64'd1);

`ifdef SPI_BOOT_WAIT_EN
    // Queue a full FIFO before boot; nothing may start until boot_done
    loop = 1'b1;
    f0 = cs_falls; v0 = rxv_cnt;
    for (int i = 0; i < 8; i++) push_a({8'(i + 1), 48'h0, 8'h5a}, dummy);
    check("boot_full_ready", 64'(wready), 64'd0);
    tick(1000);
    check("boot_cs_held", 64'(cs_falls - f0), 64'd0);
    check("boot_cs_high", 64'(cs), 64'd1);
    boot_done = 1'b1;
    tick();
    boot_done = 1'b0;
    tick();
    check("boot_start_cs", 64'(cs), 64'd0);
    check("boot_ready_after_pop", 64'(wready), 64'd1);
    wait_idle_a();
    check("boot_rx_count", 64'(rxv_cnt - v0), 64'd8);
    check("boot_one_window", 64'(cs_falls - f0), 64'd1);
    check("boot_last_rx", rxw, {8'd8, 48'h0, 8'h5a});
`endif

    // Single word, CIPO held low
    loop = 1'b0; cipo_drv = 1'b0;
    r0 = rises; v0 = rxv_cnt;
    push_a(64'h0a000000000000ff, hs);
    wait_idle_a();
    t = cs_fall_cyc - hs;
    check("t1_cs_latency_le2", 64'(t >= 1 && t <= 2), 64'd1);
    check("t1_rises", 64'(rises - r0), 64'd64);
    seq = '0;
    for (int k = 0; k < 64; k++) seq[k] = tx_q[r0 + k];
    // bit k in send order: 8 ones, 48 zeros, then 0x0a MSB-first -> bits[63:56]=8'h50
    check("t1_copi_order", seq, 64'h50000000000000ff);
    check("t1_first_rise", 64'(rise_q[r0] - cs_fall_cyc), 64'd2);
    check("t1_sck_spacing", 64'(bad_gaps(r0, 64, 4)), 64'd0);
    check("t1_cs_release", 64'(cs_rise_cyc - rise_q[r0 + 63]), 64'd4);
    check("t1_rx_word", rxw, 64'd0);
    check("t1_rx_pulses", 64'(rxv_cnt - v0), 64'd1);

    // Loopback single word
    loop = 1'b1;
    v0 = rxv_cnt;
    push_a(64'h00000000005fffff, dummy);
    wait_idle_a();
    check("t2_rx_pulses", 64'(rxv_cnt - v0), 64'd1);
    check("t2_rx_word", rxw_q[v0], 64'h00000000005fffff);
    check("t2_word_time", 64'(rxv_q[v0] - cs_fall_cyc), 64'd256);

    // Three queued words, one CS window
    w3[0] = 64'h01000000000000aa; w3[1] = 64'h00000000005fffff; w3[2] = 64'h0100000000000000;
    r0 = rises; f0 = cs_falls; v0 = rxv_cnt;
    for (int i = 0; i < 3; i++) push_a(w3[i], dummy);
    wait_idle_a();
    check("t3_cs_windows", 64'(cs_falls - f0), 64'd1);
    check("t3_rises", 64'(rises - r0), 64'd192);
    check("t3_sck_spacing", 64'(bad_gaps(r0, 192, 4)), 64'd0);
    check("t3_rx_pulses", 64'(rxv_cnt - v0), 64'd3);
    check("t3_rx_gap01", 64'(rxv_q[v0 + 1] - rxv_q[v0]), 64'd256);
    check("t3_rx_gap12", 64'(rxv_q[v0 + 2] - rxv_q[v0 + 1]), 64'd256);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_tx_word%0d", i), decode(r0 + 64*i), w3[i]);
      check($sformatf("t3_rx_word%0d", i), rxw_q[v0 + i], w3[i]);
    end

    // Fill the FIFO while a word is in flight
    f0 = cs_falls; v0 = rxv_cnt;
    for (int i = 0; i < 9; i++) push_a({56'h00c0ffee000000, 8'(i)}, dummy);
    check("full_ready_low", 64'(wready), 64'd0);
    wait_idle_a();
    check("full_rx_pulses", 64'(rxv_cnt - v0), 64'd9);
    check("full_one_window", 64'(cs_falls - f0), 64'd1);
    check("full_last_rx", rxw, 64'h00c0ffee00000008);

    // Reset after the 20th SCK rise of a word
    v0 = rxv_cnt; r0 = rises;
    push_a(64'hffffffffffffffff, dummy);
    wait_rises_a(r0 + 20);
    rst = 1'b1;
    tick();
    check("mid_rst_cs", 64'(cs), 64'd1);
    check("mid_rst_sck", 64'(sck), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_rxv", 64'(rxv), 64'd0);
    tick(2);
    rst = 1'b0;
    tick(4);
    check("mid_rst_no_rx", 64'(rxv_cnt - v0), 64'd0);
    r0 = rises;
    push_a(64'h0123456789abcdef, dummy);
    wait_idle_a();
    check("post_rst_rises", 64'(rises - r0), 64'd64);
    check("post_rst_tx", decode(r0), 64'h0123456789abcdef);
    check("post_rst_rx", rxw, 64'h0123456789abcdef);

    // CLKDIV=1 instance: SCK every other cycle, 128-cycle word
    win1 = 64'hfedcba9876543210;
    wvalid1 = 1'b1;
    t = 0;
    while (!wready1 && t < 100) begin
      tick();
      t++;
    end
    tick();
    wvalid1 = 1'b0;
    t = 0;
    while (busy1 && t < 2000) begin
      tick();
      t++;
    end
    if (busy1) check("div1_timeout", 64'd0, 64'd1);
    tick(4);
    check("div1_rises", 64'(rises1), 64'd64);
    bad = 0;
    for (int i = 1; i < 64; i++) if (rise1_q[i] - rise1_q[i - 1] != 2) bad++;
    check("div1_sck_spacing", 64'(bad), 64'd0);
    check("div1_word_time", 64'(rxv1_cyc - cs1_fall_cyc), 64'd128);
    check("div1_rx_pulses", 64'(rxv1_cnt), 64'd1);
    check("div1_rx_word", rxw1, 64'hfedcba9876543210);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
